tft_pic_bounce: RTL and testbench



---
 rtl/tft_pkg.sv | 74 +++++++
 rtl/tft_pic_bounce_if.sv | 26 ++
 rtl/tft_bounce_pos.sv | 88 ++++++++
 rtl/tft_pic_bounce.sv | 70 +++++++
 tb/tb_tft_pic_bounce.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/tft_pkg.sv
// Shared definitions for the 480x272 TFT picture path: geometry, RGB565 palette,
// colorbar lookup and the bounce-controller types.
package tft_pkg;

    localparam logic [9:0] H_VALID     = 10'd480;
    localparam logic [9:0] V_VALID     = 10'd272;
    localparam logic [9:0] BAR_WIDTH   = 10'd48;
    localparam logic [9:0] PIX_INVALID = 10'h3FF;

    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;
    localparam logic [15:0] RGB_ORANGE  = 16'hFC00;
    localparam logic [15:0] RGB_GRAY    = 16'h8410;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_MOVE  = 2'd2
    } bounce_state_e;

    // dir = 1 moves toward the far edge (right / down), dir = 0 toward zero.
    typedef struct packed {
        logic [9:0] pos;
        logic       dir;
    } axis_t;

    function automatic logic [15:0] barColor(input logic [9:0] x);
        logic [9:0] idx;
        idx = x / BAR_WIDTH;
        case (idx)
            10'd0:   barColor = RGB_RED;
            10'd1:   barColor = RGB_GREEN;
            10'd2:   barColor = RGB_BLUE;
            10'd3:   barColor = RGB_MAGENTA;
            10'd4:   barColor = RGB_YELLOW;
            10'd5:   barColor = RGB_CYAN;
            10'd6:   barColor = RGB_WHITE;
            10'd7:   barColor = RGB_BLACK;
            10'd8:   barColor = RGB_ORANGE;
            10'd9:   barColor = RGB_GRAY;
            default: barColor = RGB_BLACK;
        endcase
    endfunction

    // The forward sum is widened to 11 bits so a large position can never wrap past the limit.
    function automatic axis_t stepAxis(input axis_t cur, input logic [9:0] limit,
                                       input logic [9:0] step);
        axis_t nxt;
        nxt = cur;
        if (cur.dir) begin
            if (({1'b0, cur.pos} + {1'b0, step}) >= {1'b0, limit}) begin
                nxt.pos = limit;
                nxt.dir = 1'b0;
            end else begin
                nxt.pos = cur.pos + step;
            end
        end else begin
            if (cur.pos <= step) begin
                nxt.pos = '0;
                nxt.dir = 1'b1;
            end else begin
                nxt.pos = cur.pos - step;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/tft_pic_bounce_if.sv
// Pixel request/response bundle between the TFT timing controller and the picture source.
interface tft_pic_bounce_if;

    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        move_en;
    logic [15:0] pix_data;
    logic        frame_end;

    modport master (
        output pix_x,
        output pix_y,
        output move_en,
        input  pix_data,
        input  frame_end
    );

    modport slave (
        input  pix_x,
        input  pix_y,
        input  move_en,
        output pix_data,
        output frame_end
    );

endinterface

// File: rtl/tft_bounce_pos.sv
// Square position controller: counts frames and steps the square once every FRAME_DIV frames,
// always right after frame_end so the visible picture never changes mid-frame.
module tft_bounce_pos
    import tft_pkg::*;
#(
    parameter int unsigned BLK_SIZE   = 32,
    parameter int unsigned STEP       = 2,
    parameter int unsigned FRAME_DIV  = 2,
    parameter logic [9:0]  X_INIT     = 10'd0,
    parameter logic [9:0]  Y_INIT     = 10'd0,
    parameter logic        DIR_X_INIT = 1'b1,
    parameter logic        DIR_Y_INIT = 1'b1
) (
    input  logic       tft_clk,
    input  logic       sys_rst_n,
    input  logic       frame_end_i,
    input  logic       move_en_i,
    output logic [9:0] x_pos_o,
    output logic [9:0] y_pos_o
);

    localparam logic [9:0]  X_LIMIT  = H_VALID - 10'(BLK_SIZE);
    localparam logic [9:0]  Y_LIMIT  = V_VALID - 10'(BLK_SIZE);
    localparam logic [9:0]  STEP_W   = 10'(STEP);
    localparam logic [15:0] CNT_LAST = 16'(FRAME_DIV - 1);

    bounce_state_e state_q, state_d;
    logic [15:0]   frameCnt_q, frameCnt_d;
    axis_t         xAxis_q, xAxis_d;
    axis_t         yAxis_q, yAxis_d;

    always_ff @(posedge tft_clk) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            frameCnt_q <= '0;
            xAxis_q    <= '{pos: X_INIT, dir: DIR_X_INIT};
            yAxis_q    <= '{pos: Y_INIT, dir: DIR_Y_INIT};
        end else begin
            state_q    <= state_d;
            frameCnt_q <= frameCnt_d;
            xAxis_q    <= xAxis_d;
            yAxis_q    <= yAxis_d;
        end
    end

    // A deasserted move_en beats a coincident frame_end; an entered MOVE still completes.
    always_comb begin
        state_d    = state_q;
        frameCnt_d = frameCnt_q;
        xAxis_d    = xAxis_q;
        yAxis_d    = yAxis_q;
        case (state_q)
            ST_IDLE: begin
                frameCnt_d = '0;
                if (move_en_i) begin
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (!move_en_i) begin
                    state_d    = ST_IDLE;
                    frameCnt_d = '0;
                end else if (frame_end_i) begin
                    if (frameCnt_q >= CNT_LAST) begin
                        frameCnt_d = '0;
                        state_d    = ST_MOVE;
                    end else begin
                        frameCnt_d = frameCnt_q + 16'd1;
                    end
                end
            end
            ST_MOVE: begin
                xAxis_d    = stepAxis(xAxis_q, X_LIMIT, STEP_W);
                yAxis_d    = stepAxis(yAxis_q, Y_LIMIT, STEP_W);
                frameCnt_d = '0;
                state_d    = move_en_i ? ST_COUNT : ST_IDLE;
            end
            default: begin
                state_d    = ST_IDLE;
                frameCnt_d = '0;
            end
        endcase
    end

    assign x_pos_o = xAxis_q.pos;
    assign y_pos_o = yAxis_q.pos;

endmodule

// File: rtl/tft_pic_bounce.sv
// Picture source for the TFT path: colorbar background with a bouncing solid square,
// one registered pixel per cycle plus a frame_end pulse on the last active pixel.
module tft_pic_bounce
    import tft_pkg::*;
#(
    parameter int unsigned BLK_SIZE   = 32,
    parameter int unsigned STEP       = 2,
    parameter int unsigned FRAME_DIV  = 2,
    parameter logic [15:0] BLK_COLOR  = 16'hFFFF,
    parameter logic [9:0]  X_INIT     = 10'd0,
    parameter logic [9:0]  Y_INIT     = 10'd0,
    parameter logic        DIR_X_INIT = 1'b1,
    parameter logic        DIR_Y_INIT = 1'b1
) (
    input logic             tft_clk,
    input logic             sys_rst_n,
    tft_pic_bounce_if.slave bus
);

    localparam logic [9:0] BLK_W = 10'(BLK_SIZE);

    logic [9:0]  xPos, yPos;
    logic [15:0] pixData_q, pixData_d;
    logic        frameEnd_q, frameEnd_d;
    logic        inActive, inBlock;

    tft_bounce_pos #(
        .BLK_SIZE   (BLK_SIZE),
        .STEP       (STEP),
        .FRAME_DIV  (FRAME_DIV),
        .X_INIT     (X_INIT),
        .Y_INIT     (Y_INIT),
        .DIR_X_INIT (DIR_X_INIT),
        .DIR_Y_INIT (DIR_Y_INIT)
    ) uPos (
        .tft_clk     (tft_clk),
        .sys_rst_n   (sys_rst_n),
        .frame_end_i (frameEnd_q),
        .move_en_i   (bus.move_en),
        .x_pos_o     (xPos),
        .y_pos_o     (yPos)
    );

    // Blanking codes and out-of-range coordinates take priority over the square and the bars.
    always_comb begin
        pixData_d  = RGB_BLACK;
        inActive   = (bus.pix_x != PIX_INVALID) && (bus.pix_y != PIX_INVALID) &&
                     (bus.pix_x < H_VALID) && (bus.pix_y < V_VALID);
        inBlock    = (bus.pix_x >= xPos) && (bus.pix_x < (xPos + BLK_W)) &&
                     (bus.pix_y >= yPos) && (bus.pix_y < (yPos + BLK_W));
        frameEnd_d = (bus.pix_x == (H_VALID - 10'd1)) && (bus.pix_y == (V_VALID - 10'd1));
        if (inActive) begin
            pixData_d = inBlock ? BLK_COLOR : barColor(bus.pix_x);
        end
    end

    always_ff @(posedge tft_clk) begin
        if (!sys_rst_n) begin
            pixData_q  <= RGB_BLACK;
            frameEnd_q <= 1'b0;
        end else begin
            pixData_q  <= pixData_d;
            frameEnd_q <= frameEnd_d;
        end
    end

    assign bus.pix_data  = pixData_q;
    assign bus.frame_end = frameEnd_q;

endmodule

// File: tb/tb_tft_pic_bounce.sv
// Directed bench for tft_pic_bounce: default instance plus two instances started at an edge
// and at a corner, all driven with the same pixel stream.
module tb_tft_pic_bounce;
    import tft_pkg::*;

    logic tft_clk;
    logic sys_rst_n;
    int   nChecks = 0;
    int   nFails  = 0;
    int   moveCnt = 0;
    int   moveOrphan = 0;
    int   movesBefore;
    logic feSeen = 1'b0;

    tft_pic_bounce_if busA ();
    tft_pic_bounce_if busB ();
    tft_pic_bounce_if busC ();

    tft_pic_bounce dut (
        .tft_clk   (tft_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (busA)
    );

    tft_pic_bounce #(
        .X_INIT     (10'd447),
        .Y_INIT     (10'd100),
        .DIR_X_INIT (1'b1),
        .DIR_Y_INIT (1'b1)
    ) dutEdge (
        .tft_clk   (tft_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (busB)
    );

    tft_pic_bounce #(
        .X_INIT     (10'd0),
        .Y_INIT     (10'd240),
        .DIR_X_INIT (1'b0),
        .DIR_Y_INIT (1'b1)
    ) dutCorner (
        .tft_clk   (tft_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (busC)
    );

    initial tft_clk = 1'b0;
    always #5 tft_clk = ~tft_clk;

    // Counts MOVE cycles of the default instance and flags any not preceded by frame_end.
    always @(posedge tft_clk) begin
        if (dut.uPos.state_q == ST_MOVE) begin
            moveCnt++;
            if (!feSeen) moveOrphan++;
        end
        feSeen = busA.frame_end;
    end

    task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y, input logic en);
        busA.pix_x = x; busA.pix_y = y; busA.move_en = en;
        busB.pix_x = x; busB.pix_y = y; busB.move_en = en;
        busC.pix_x = x; busC.pix_y = y; busC.move_en = en;
        @(posedge tft_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic runFrame(input logic en);
        applyStimulus(10'd479, 10'd271, en);
        checkOutput("frame_end pulse", 16'(busA.frame_end), 16'd1);
        applyStimulus(PIX_INVALID, PIX_INVALID, en);
        checkOutput("frame_end one cycle", 16'(busA.frame_end), 16'd0);
        applyStimulus(PIX_INVALID, PIX_INVALID, en);
        applyStimulus(PIX_INVALID, PIX_INVALID, en);
    endtask

    initial begin
        sys_rst_n = 1'b0;
        applyStimulus(10'd10, 10'd10, 1'b1);
        applyStimulus(10'd10, 10'd10, 1'b1);
        checkOutput("reset pix_data", busA.pix_data, 16'h0000);
        checkOutput("reset frame_end", 16'(busA.frame_end), 16'd0);
        checkOutput("reset x_pos", 16'(dut.xPos), 16'd0);
        checkOutput("reset y_pos", 16'(dut.yPos), 16'd0);
        checkOutput("reset dir_x", 16'(dut.uPos.xAxis_q.dir), 16'd1);
        checkOutput("reset dir_y", 16'(dut.uPos.yAxis_q.dir), 16'd1);
        checkOutput("reset state", 16'(dut.uPos.state_q), 16'(ST_IDLE));

        sys_rst_n = 1'b1;
        applyStimulus(10'd10, 10'd10, 1'b0);
        checkOutput("square at origin", busA.pix_data, 16'hFFFF);
        applyStimulus(10'd60, 10'd10, 1'b0);
        checkOutput("bar 1", busA.pix_data, 16'h07E0);
        applyStimulus(10'd100, 10'd10, 1'b0);
        checkOutput("bar 2", busA.pix_data, 16'h001F);
        applyStimulus(10'd335, 10'd100, 1'b0);
        checkOutput("bar 6 last col", busA.pix_data, 16'hFFFF);
        applyStimulus(10'd336, 10'd100, 1'b0);
        checkOutput("bar 7 first col", busA.pix_data, 16'h0000);
        applyStimulus(10'd479, 10'd0, 1'b0);
        checkOutput("bar 9", busA.pix_data, 16'h8410);
        applyStimulus(10'd31, 10'd31, 1'b0);
        checkOutput("square far corner", busA.pix_data, 16'hFFFF);
        applyStimulus(10'd32, 10'd10, 1'b0);
        checkOutput("right of square", busA.pix_data, 16'hF800);
        applyStimulus(10'd10, 10'd32, 1'b0);
        checkOutput("below square", busA.pix_data, 16'hF800);
        applyStimulus(PIX_INVALID, 10'd5, 1'b0);
        checkOutput("invalid x", busA.pix_data, 16'h0000);
        applyStimulus(10'd5, PIX_INVALID, 1'b0);
        checkOutput("invalid y", busA.pix_data, 16'h0000);
        applyStimulus(10'd480, 10'd5, 1'b0);
        checkOutput("x out of range", busA.pix_data, 16'h0000);
        applyStimulus(10'd5, 10'd272, 1'b0);
        checkOutput("y out of range", busA.pix_data, 16'h0000);

        applyStimulus(10'd479, 10'd270, 1'b0);
        checkOutput("no frame_end row 270", 16'(busA.frame_end), 16'd0);
        applyStimulus(10'd478, 10'd271, 1'b0);
        checkOutput("no frame_end col 478", 16'(busA.frame_end), 16'd0);
        runFrame(1'b0);
        checkOutput("last pixel colour", busA.pix_data, 16'h0000);
        checkOutput("idle holds x", 16'(dut.xPos), 16'd0);

        movesBefore = moveCnt;
        applyStimulus(PIX_INVALID, PIX_INVALID, 1'b1);
        checkOutput("enter count", 16'(dut.uPos.state_q), 16'(ST_COUNT));
        runFrame(1'b1);
        checkOutput("no move after 1 frame", 16'(dut.xPos), 16'd0);
        runFrame(1'b1);
        checkOutput("x after 1 move", 16'(dut.xPos), 16'd2);
        checkOutput("y after 1 move", 16'(dut.yPos), 16'd2);
        checkOutput("edge x clamp", 16'(dutEdge.xPos), 16'd448);
        checkOutput("edge dir_x left", 16'(dutEdge.uPos.xAxis_q.dir), 16'd0);
        checkOutput("edge y", 16'(dutEdge.yPos), 16'd102);
        checkOutput("corner x", 16'(dutCorner.xPos), 16'd0);
        checkOutput("corner y", 16'(dutCorner.yPos), 16'd240);
        checkOutput("corner dir_x right", 16'(dutCorner.uPos.xAxis_q.dir), 16'd1);
        checkOutput("corner dir_y up", 16'(dutCorner.uPos.yAxis_q.dir), 16'd0);
        runFrame(1'b1);
        runFrame(1'b1);
        checkOutput("x after 4 frames", 16'(dut.xPos), 16'd4);
        checkOutput("y after 4 frames", 16'(dut.yPos), 16'd4);
        checkOutput("move count", 16'(moveCnt - movesBefore), 16'd2);
        checkOutput("moves follow frame_end", 16'(moveOrphan), 16'd0);
        checkOutput("edge x step back", 16'(dutEdge.xPos), 16'd446);
        checkOutput("corner x leaves", 16'(dutCorner.xPos), 16'd2);
        checkOutput("corner y leaves", 16'(dutCorner.yPos), 16'd238);
        applyStimulus(10'd4, 10'd4, 1'b1);
        checkOutput("square moved in", busA.pix_data, 16'hFFFF);
        applyStimulus(10'd3, 10'd4, 1'b1);
        checkOutput("left of moved square", busA.pix_data, 16'hF800);

        runFrame(1'b1);
        applyStimulus(10'd479, 10'd271, 1'b1);
        applyStimulus(PIX_INVALID, PIX_INVALID, 1'b0);
        applyStimulus(PIX_INVALID, PIX_INVALID, 1'b0);
        applyStimulus(PIX_INVALID, PIX_INVALID, 1'b0);
        checkOutput("deassert wins x", 16'(dut.xPos), 16'd4);
        checkOutput("deassert idle", 16'(dut.uPos.state_q), 16'(ST_IDLE));
        checkOutput("deassert no move", 16'(moveCnt - movesBefore), 16'd2);

        applyStimulus(PIX_INVALID, PIX_INVALID, 1'b1);
        runFrame(1'b1);
        checkOutput("count cleared on idle", 16'(dut.xPos), 16'd4);
        runFrame(1'b1);
        checkOutput("move after reenable", 16'(dut.xPos), 16'd6);

        sys_rst_n = 1'b0;
        applyStimulus(10'd200, 10'd150, 1'b1);
        checkOutput("mid reset pix_data", busA.pix_data, 16'h0000);
        checkOutput("mid reset x", 16'(dut.xPos), 16'd0);
        checkOutput("mid reset y", 16'(dut.yPos), 16'd0);
        checkOutput("mid reset state", 16'(dut.uPos.state_q), 16'(ST_IDLE));
        sys_rst_n = 1'b1;
        applyStimulus(10'd10, 10'd10, 1'b0);
        checkOutput("square back at origin", busA.pix_data, 16'hFFFF);
        applyStimulus(10'd40, 10'd10, 1'b0);
        checkOutput("bar 0 after reset", busA.pix_data, 16'hF800);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
